// File: rtl/dds_dac_spi.sv
// dds_dac_spi: decimating serializer from the DDS sample stream to a
// 3-wire serial DAC (TLC5615 style). It takes one sample per frame through
// a valid/ready handshake. The sample is sent MSB first, followed by zero pad
// bits, and the DAC samples data on the rising edge of SCLK. After each frame
// cs_n stays high for a guard interval before the next sample is accepted.
module dds_dac_spi #(
  parameter int DATA_W     = 10,
  parameter int FRAME_BITS = 12,
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYC    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              dac_cs_n,
  output logic              dac_sclk,
  output logic              dac_din,
  output logic              frame_done
);

  localparam int PAD_W   = FRAME_BITS - DATA_W;
  localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(FRAME_BITS + 1);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [FRAME_BITS-1:0] sreg_q, sreg_d;
  logic                  ready_q, ready_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic                  sdo_q, sdo_d;
  logic                  done_q, done_d;

  logic [FRAME_BITS-1:0] load_word;
  logic [FRAME_BITS-1:0] sreg_shift;

  // The frame word is the sample left-aligned, with zero pad bits below it
  assign load_word = FRAME_BITS'(din) << PAD_W;

  // Frame sequencing: next-state and next-output logic for every register
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    sreg_d     = sreg_q;
    ready_d    = ready_q;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    sdo_d      = sdo_q;
    done_d     = 1'b0;
    sreg_shift = sreg_q << 1;

    unique case (state_q)
      IDLE: begin
        if (din_valid && ready_q) begin
          sreg_d  = load_word;
          sdo_d   = din[DATA_W-1];
          cs_n_d  = 1'b0;
          ready_d = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (cnt_q == DIV_LAST) begin
          sclk_d  = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              sdo_d   = 1'b0;
              state_d = HOLD;
            end else begin
              sreg_d = sreg_shift;
              sdo_d  = sreg_shift[FRAME_BITS-1];
              bit_d  = bit_q + BIT_ONE;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          ready_d = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registers: reset aborts any frame in flight and returns to idle outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
      ready_q <= 1'b1;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      sdo_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      ready_q <= ready_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      sdo_q   <= sdo_d;
      done_q  <= done_d;
    end
  end

  assign din_ready  = ready_q;
  assign dac_cs_n   = cs_n_q;
  assign dac_sclk   = sclk_q;
  assign dac_din    = sdo_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_dds_dac_spi.sv
// tb_dds_dac_spi: bench for dds_dac_spi. Instance A uses the default timing
// and instance B uses the fastest timing (CLK_DIV=1, GAP_CYC=1). A timeline
// model gives the expected outputs from the number of edges since the accept
// edge. The bench compares every output on every falling clk edge. It also
// reassembles each frame from the SCLK rising edges and scores it against
// the accepted sample.
module tb_dds_dac_spi;

  localparam int DW    = 10;
  localparam int FB    = 12;
  localparam int CD_A  = 4;
  localparam int GAP_A = 16;
  localparam int CD_B  = 1;
  localparam int GAP_B = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din_a = '0;
  logic [DW-1:0] din_b = '0;
  logic          valid_a = 1'b0;
  logic          valid_b = 1'b0;
  logic          ready_a, cs_n_a, sclk_a, sdo_a, done_a;
  logic          ready_b, cs_n_b, sclk_b, sdo_b, done_b;

  int assertions = 0;
  int failures   = 0;
  int cyc        = 0;

  // Free-running clock and edge counter (edge number of the latest rising edge)
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dds_dac_spi #(.DATA_W(DW), .FRAME_BITS(FB), .CLK_DIV(CD_A), .GAP_CYC(GAP_A)) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(valid_a), .din_ready(ready_a),
    .dac_cs_n(cs_n_a), .dac_sclk(sclk_a), .dac_din(sdo_a), .frame_done(done_a)
  );

  dds_dac_spi #(.DATA_W(DW), .FRAME_BITS(FB), .CLK_DIV(CD_B), .GAP_CYC(GAP_B)) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(valid_b), .din_ready(ready_b),
    .dac_cs_n(cs_n_b), .dac_sclk(sclk_b), .dac_din(sdo_b), .frame_done(done_b)
  );

  // Comparison helper: counts every check and reports mismatches
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Timeline model: expected {ready, cs_n, sclk, din, done} after edge t of a frame.
  // t=0 is the accept edge. SCLK is high during odd CLK_DIV-length slots.
  // Bit k is presented during the 2*CLK_DIV-cycle window numbered k.
  function automatic logic [4:0] model_out(input bit act, input int t, input int cd, input int gp,
                                           input logic [FB-1:0] w);
    int tend, q, idx;
    logic [4:0] r;
    tend = cd * (2 * FB + 1);
    r = 5'b11000;
    if (act && t < tend + gp) begin
      if (t < tend) begin
        q   = t / cd;
        idx = t / (2 * cd);
        r = {1'b0, 1'b0, ((q % 2) == 1) && (q < 2 * FB), (idx < FB) ? w[FB-1-idx] : 1'b0, 1'b0};
      end else begin
        r = {1'b0, 1'b1, 1'b0, 1'b0, (t == tend)};
      end
    end
    return r;
  endfunction

  function automatic bit model_ready(input bit act, input int t, input int cd, input int gp);
    return !act || (t >= cd * (2 * FB + 1) + gp);
  endfunction

  bit            act_a = 1'b0, act_b = 1'b0;
  int            t_a = 0, t_b = 0;
  logic [FB-1:0] w_a = '0, w_b = '0;
  logic [FB-1:0] exp_qa[$], exp_qb[$];
  int            acc_qa[$], acc_qb[$];

  // Model update: accept when idle and valid, otherwise advance the frame timeline.
  // Reset discards any frame in progress together with its expected word.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      act_a = 1'b0;
      act_b = 1'b0;
      exp_qa.delete();
      exp_qb.delete();
    end else begin
      if (model_ready(act_a, t_a, CD_A, GAP_A) && valid_a) begin
        act_a = 1'b1; t_a = 0; w_a = {din_a, 2'b00};
        exp_qa.push_back(w_a); acc_qa.push_back(cyc + 1);
      end else if (act_a && t_a < 1000000) begin
        t_a++;
      end
      if (model_ready(act_b, t_b, CD_B, GAP_B) && valid_b) begin
        act_b = 1'b1; t_b = 0; w_b = {din_b, 2'b00};
        exp_qb.push_back(w_b); acc_qb.push_back(cyc + 1);
      end else if (act_b && t_b < 1000000) begin
        t_b++;
      end
    end
  end

  logic [FB-1:0] cap_a = '0, cap_b = '0;
  int            nb_a = 0, nb_b = 0;
  int            sclk_edges_a = 0;

  // Serial capture: shift in the data bit on each SCLK rising edge.
  // A rising edge is only legal while chip select is low.
  always @(posedge sclk_a) begin
    checkOutput("sclk_with_cs_a", cs_n_a, 0);
    cap_a = {cap_a[FB-2:0], sdo_a};
    nb_a++;
    sclk_edges_a++;
  end
  always @(posedge sclk_b) begin
    checkOutput("sclk_with_cs_b", cs_n_b, 0);
    cap_b = {cap_b[FB-2:0], sdo_b};
    nb_b++;
  end
  always @(negedge cs_n_a) begin cap_a = '0; nb_a = 0; end
  always @(negedge cs_n_b) begin cap_b = '0; nb_b = 0; end

  logic          prev_ready_a = 1'b1, prev_ready_b = 1'b1;
  int            done_edge_a = 0, done_edge_b = 0, ready_edge_a = 0, ready_edge_b = 0;
  logic [FB-1:0] last_word_a = '0, last_word_b = '0;

  // Per-cycle compare against the model, plus scoreboarding of completed frames
  always @(negedge clk) begin
    checkOutput("outs_a", {ready_a, cs_n_a, sclk_a, sdo_a, done_a}, model_out(act_a, t_a, CD_A, GAP_A, w_a));
    checkOutput("outs_b", {ready_b, cs_n_b, sclk_b, sdo_b, done_b}, model_out(act_b, t_b, CD_B, GAP_B, w_b));
    if (done_a === 1'b1) begin
      done_edge_a = cyc;
      last_word_a = cap_a;
      checkOutput("bits_a", nb_a, FB);
      if (exp_qa.size() == 0) begin
        assertions++; failures++;
        $display("[TB] FAIL word_a: got %0h, expected no frame", cap_a);
      end else checkOutput("word_a", cap_a, exp_qa.pop_front());
    end
    if (done_b === 1'b1) begin
      done_edge_b = cyc;
      last_word_b = cap_b;
      checkOutput("bits_b", nb_b, FB);
      if (exp_qb.size() == 0) begin
        assertions++; failures++;
        $display("[TB] FAIL word_b: got %0h, expected no frame", cap_b);
      end else checkOutput("word_b", cap_b, exp_qb.pop_front());
    end
    if (ready_a === 1'b1 && prev_ready_a !== 1'b1) ready_edge_a = cyc;
    if (ready_b === 1'b1 && prev_ready_b !== 1'b1) ready_edge_b = cyc;
    prev_ready_a = ready_a;
    prev_ready_b = ready_b;
  end

  // One-cycle valid pulse with a sample on the selected instance
  task automatic applyStimulus(input bit sel, input logic [DW-1:0] value);
    @(posedge clk); #1;
    if (!sel) begin din_a = value; valid_a = 1'b1; end
    else      begin din_b = value; valid_b = 1'b1; end
    @(posedge clk); #1;
    if (!sel) valid_a = 1'b0;
    else      valid_b = 1'b0;
  endtask

  // Bounded wait for din_ready; a timeout counts as a failed check
  task automatic waitReady(input bit sel, input int budget);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if ((!sel && ready_a === 1'b1) || (sel && ready_b === 1'b1)) break;
      n++;
      if (n > budget) begin
        assertions++; failures++;
        $display("[TB] FAIL ready_timeout_%0d: got 0, expected 1 within %0d cycles", sel, budget);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed tests, then randomized traffic on both instances
  initial begin
    int e, n;

    // Reset held, then released with no valid: idle outputs, no SCLK activity
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("t1_idle_a", {ready_a, cs_n_a, sclk_a, sdo_a, done_a}, 5'b11000);
    checkOutput("t1_idle_b", {ready_b, cs_n_b, sclk_b, sdo_b, done_b}, 5'b11000);
    checkOutput("t1_no_sclk", sclk_edges_a, 0);

    // Single 0x2AA frame with the default timing
    applyStimulus(1'b0, 10'h2AA);
    waitReady(1'b0, 200);
    checkOutput("t2_word", last_word_a, 12'hAA8);
    checkOutput("t2_done_lat", done_edge_a - acc_qa[$], 100);
    checkOutput("t2_ready_lat", ready_edge_a - acc_qa[$], 116);
    checkOutput("t2_sclk_edges", sclk_edges_a, 12);

    // valid held high with din incrementing: one sample taken every 117 cycles
    acc_qa.delete();
    @(posedge clk); #1;
    din_a = 10'h100; valid_a = 1'b1;
    repeat (3 * 117) begin
      @(posedge clk); #1;
      din_a = din_a + 10'd1;
    end
    valid_a = 1'b0;
    waitReady(1'b0, 300);
    checkOutput("t3_frames", acc_qa.size(), 3);
    if (acc_qa.size() >= 3) begin
      checkOutput("t3_period1", acc_qa[1] - acc_qa[0], 117);
      checkOutput("t3_period2", acc_qa[2] - acc_qa[1], 117);
    end
    checkOutput("t3_last_word", last_word_a, 12'h7A8);

    // All-ones then all-zeros: pad bits stay zero
    applyStimulus(1'b0, 10'h3FF);
    waitReady(1'b0, 200);
    checkOutput("t4_ones", last_word_a, 12'hFFC);
    applyStimulus(1'b0, 10'h000);
    waitReady(1'b0, 200);
    checkOutput("t4_zeros", last_word_a, 12'h000);
    checkOutput("t4_din_idle", sdo_a, 0);

    // Asynchronous reset between edges 50 and 51 of a frame, then a clean frame
    applyStimulus(1'b0, 10'($urandom_range(1, 1023)));
    e = acc_qa[$];
    n = 0;
    while (cyc < e + 50 && n < 200) begin
      @(negedge clk);
      n++;
    end
    #1 rst = 1'b1;
    #1 checkOutput("t5_abort", {ready_a, cs_n_a, sclk_a, sdo_a, done_a}, 5'b11000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 10'h155);
    waitReady(1'b0, 200);
    checkOutput("t5_word", last_word_a, 12'h554);
    checkOutput("t5_done_lat", done_edge_a - acc_qa[$], 100);

    // Fastest timing: frame 0x201, back-to-back accepts 27 cycles apart
    acc_qb.delete();
    @(posedge clk); #1;
    din_b = 10'h201; valid_b = 1'b1;
    n = 0;
    while (acc_qb.size() < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    #1 valid_b = 1'b0;
    checkOutput("t6_accepts", acc_qb.size(), 2);
    if (acc_qb.size() >= 2) begin
      checkOutput("t6_period", acc_qb[1] - acc_qb[0], 27);
      checkOutput("t6_done_lat", done_edge_b - acc_qb[0], 25);
      checkOutput("t6_ready_lat", ready_edge_b - acc_qb[0], 26);
    end
    checkOutput("t6_word", last_word_b, 12'h804);
    waitReady(1'b1, 100);

    // Random samples and sporadic valid on both instances
    repeat (1500) begin
      @(posedge clk); #1;
      valid_a = ($urandom_range(0, 3) == 0);
      din_a   = 10'($urandom);
      valid_b = ($urandom_range(0, 2) == 0);
      din_b   = 10'($urandom);
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
    waitReady(1'b0, 200);
    waitReady(1'b1, 100);
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/dds_dac_spi.md
Name: dds_dac_spi

Overview:
Output stage directly downstream of the DDS waveform generator. It takes the generator's 10-bit ROM sample and serializes it to a 3-wire serial DAC such as the TLC5615 (12-bit frame, MSB first, data sampled on the DAC on the SCLK rising edge). The DDS produces a sample every clk, and the DAC is much slower, so the block decimates: it captures one sample per frame through a valid/ready handshake and ignores samples in between.

Parameters:
DATA_W, 10, sample width.
FRAME_BITS, 12, bits per DAC frame: DATA_W data bits followed by (FRAME_BITS-DATA_W) zero pad bits; must be >= DATA_W.
CLK_DIV, 4, clk cycles per SCLK half-period; must be >= 1.
GAP_CYC, 16, clk cycles cs_n is held high after a frame (DAC conversion/update time); must be >= 1.

Ports:
clk  input  1  system clock, the same clk that drives the DDS.
rst  input  1  asynchronous, active-high reset.
din  input  DATA_W  sample from the DDS ROM output, unsigned.
din_valid  input  1  sample valid; may be tied high.
din_ready  output  1  block can accept a sample this cycle.
dac_cs_n  output  1  DAC chip select, active low.
dac_sclk  output  1  DAC serial clock, idle low.
dac_din  output  1  DAC serial data, MSB first.
frame_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- All outputs are registered. Reset values: din_ready=1, dac_cs_n=1, dac_sclk=0, dac_din=0, frame_done=0. State = IDLE.
- Reset asserted at any time forces the reset values asynchronously and aborts any frame. No frame_done pulse is produced for an aborted frame.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- Accept: a transfer happens at the clk edge where din_valid && din_ready. Call this edge 0.
- At edge 0:
  - shift register <= {din, (FRAME_BITS-DATA_W) zeros}
  - dac_cs_n <= 0, dac_din <= din[DATA_W-1], din_ready <= 0
  - state <= SETUP
- While din_ready=0, din and din_valid are ignored. The captured value is not affected by later changes on din.
- SETUP: dac_sclk stays low for CLK_DIV cycles.
- SHIFT, for bit k = 0..FRAME_BITS-1:
  - dac_sclk rises at edge CLK_DIV*(1+2k).
  - dac_sclk falls at edge CLK_DIV*(2+2k).
  - On each falling edge, dac_din updates to the next bit. After the last bit, dac_din <= 0.
  - dac_din is therefore stable for CLK_DIV cycles on each side of every rising edge.
- HOLD: dac_sclk low and dac_cs_n low for CLK_DIV cycles after the last falling edge.
- At edge CLK_DIV*(2*FRAME_BITS+1): dac_cs_n <= 1, frame_done <= 1 for exactly one cycle, state <= GAP.
- GAP: lasts GAP_CYC cycles. At edge CLK_DIV*(2*FRAME_BITS+1)+GAP_CYC, din_ready <= 1 and state <= IDLE.
- The earliest next accept edge is CLK_DIV*(2*FRAME_BITS+1)+GAP_CYC+1.
  - Defaults: cs_n low from edge 0 to edge 100, SCLK rising edges at 4, 12, ..., 92, frame_done after edge 100, din_ready after edge 116, frame period 117 cycles with din_valid held high.
- Exactly FRAME_BITS SCLK rising edges occur per frame, all while dac_cs_n=0. There are no SCLK edges while dac_cs_n=1.
- Counter widths must hold max(CLK_DIV, GAP_CYC) and FRAME_BITS without wrap.

Test Plan:
1. Hold rst high, then release, with din_valid=0 for 20 cycles -> outputs stay at reset values, din_ready=1, no SCLK activity.
2. Defaults, din=10'h2AA, one-cycle din_valid -> bits 1,0,1,0,1,0,1,0,1,0,0,0 sampled on the 12 SCLK rising edges at edges 4..92 step 8; cs_n low from edge 0 to 100; frame_done high for 1 cycle after edge 100; din_ready=1 after edge 116.
3. din_valid tied high, din incrementing every clk -> frames start at edges 0, 117, 234. Each frame carries the din value present at its accept edge. Intermediate samples are dropped.
4. din=10'h3FF, then din=10'h000 -> serial words 111111111100 and 000000000000; pad bits always 0; dac_din=0 after the last bit.
5. Assert rst asynchronously mid-frame (e.g. between edges 50 and 51) -> cs_n=1 and sclk=0 immediately, no frame_done, din_ready=1. A following frame with din=10'h155 completes with the normal timing.
6. CLK_DIV=1, GAP_CYC=1, din=10'h201 -> SCLK rising edges at edges 1, 3, ..., 23; cs_n rises at edge 25; din_ready after edge 26; next accept at edge 27.
